// File: rtl/mmu_pkg.sv
// Shared types and sizing helpers for the matrix multiply unit front end.
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } feeder_state_t;

    localparam int MAX_LENGTH = 256;
    localparam int MAX_CNT_W  = $clog2(2 * MAX_LENGTH);

    // Zero-fill cycles needed to drain the deepest lane and cross the array diagonal.
    function automatic int flush_cycles(input int length);
        return 2 * length - 1;
    endfunction

    function automatic int cnt_width(input int length);
        return $clog2(2 * length);
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift register with synchronous clear; one lane of the wavefront skew.
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps[k] <= '0;
            end
        end else if (en) begin
            taps[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-wavefront feeder for the systolic array: skews lanes, drives enable/clear, flushes, signals Done.
// Optional FEEDER_STALL_CNT_EN adds a per-tile stall counter output Stall_Cnt.
module systolic_skew_feeder
    import mmu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 256
) (
    input  logic                            CLK,
    input  logic                            SYNC_RST,
    input  logic                            In_Valid,
    output logic                            In_Ready,
    input  logic                            In_Last,
    input  logic [0:LENGTH-1][WIDTH-1:0]    In_Vec,
    input  logic [0:LENGTH-1][WIDTH-1:0]    W_Vec,
    output logic [0:LENGTH-1][WIDTH-1:0]    Inputs,
    output logic [0:LENGTH-1][WIDTH-1:0]    Weights,
    output logic                            Array_EN,
    output logic                            Array_Clr,
    output logic                            Done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                     Stall_Cnt
`endif
);

    localparam int               CNT_W      = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(flush_cycles(LENGTH));
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    feeder_state_t state;
    feeder_state_t state_next;
    logic [CNT_W-1:0] flush_cnt;
    logic accept;
    logic advance;
    logic done_next;
    logic [0:LENGTH-1][WIDTH-1:0] in_lane;
    logic [0:LENGTH-1][WIDTH-1:0] w_lane;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        In_Ready   = 1'b0;
        accept     = 1'b0;
        Array_Clr  = 1'b0;
        advance    = 1'b0;
        in_lane    = In_Vec;
        w_lane     = W_Vec;

        // Ready depends on state alone, held low while reset is asserted.
        In_Ready  = !SYNC_RST && (state != FLUSH);
        accept    = In_Valid && In_Ready;
        Array_Clr = accept && (state == IDLE);

        case (state)
            IDLE: begin
                advance = accept;
                if (accept) begin
                    state_next = In_Last ? FLUSH : FEED;
                end
            end
            FEED: begin
                advance = accept;
                if (accept && In_Last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                advance = !SYNC_RST;
                in_lane = '0;
                w_lane  = '0;
                if (flush_cnt == CNT_ONE) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state     <= IDLE;
            flush_cnt <= '0;
            Array_EN  <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state    <= state_next;
            Array_EN <= advance;
            Done     <= done_next;
            if (state != FLUSH && state_next == FLUSH) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - CNT_ONE;
            end
        end
    end

    // Lane i sits i+1 registers deep on both edges so the array sees a diagonal wavefront.
    for (genvar lane = 0; lane < LENGTH; lane++) begin : g_lane
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (lane + 1)
        ) u_input_skew (
            .clk (CLK),
            .clr (SYNC_RST),
            .en  (advance),
            .d   (in_lane[lane]),
            .q   (Inputs[lane])
        );

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (lane + 1)
        ) u_weight_skew (
            .clk (CLK),
            .clr (SYNC_RST),
            .en  (advance),
            .d   (w_lane[lane]),
            .q   (Weights[lane])
        );
    end

`ifdef FEEDER_STALL_CNT_EN
    // Counts starved FEED cycles of the current tile; saturates and holds past Done.
    always_ff @(posedge CLK) begin
        if (SYNC_RST || Array_Clr) begin
            Stall_Cnt <= '0;
        end else if (state == FEED && !In_Valid && Stall_Cnt != '1) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`endif

endmodule
